// File: rtl/ser_deframer_pkg.sv
// Shared types and framing constants for the serial deframer.
package ser_deframer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_deframer_outreg.sv
// Output holding register for received words: valid/ready handshake plus
// overflow pulse when a completed word finds the register still occupied.
module ser_deframer_outreg
    import ser_deframer_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             po_ready,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            po       <= '0;
            po_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (load) begin
                // A consumer draining the held word this cycle frees the slot
                if (!po_valid || po_ready) begin
                    po       <= din;
                    po_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ser_deframer.sv
// Serial frame receiver: start, WIDTH data bits, optional even parity, stop.
// Define PARITY_EN to expect a parity bit after the data bits.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (0)
// S_DATA   | shifting in WIDTH data bits
// S_PARITY | checking the even-parity bit (PARITY_EN builds only)
// S_STOP   | expecting the stop bit (1)
// S_BREAK  | bad stop seen; waiting for line to return to 1
module ser_deframer
    import ser_deframer_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    input  logic             msb_first,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               msb_lat;
    logic               par_bad;
    logic               word_done;

    assign busy      = (state != S_IDLE);
    assign word_done = si_valid && (state == S_STOP) && (si == STOP_BIT) && !par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            msb_lat    <= 1'b1;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (si_valid) begin
                case (state)
                    S_IDLE: begin
                        if (si == START_BIT) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            msb_lat <= msb_first;
                            shreg   <= '0;
                            par_bad <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shreg <= msb_lat ? {shreg[WIDTH-2:0], si} : {si, shreg[WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(WIDTH-1)) begin
                            bit_cnt <= '0;
                            state   <= AFTER_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
`ifdef PARITY_EN
                    S_PARITY: begin
                        par_bad <= ^{shreg, si};
                        state   <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        if (si == STOP_BIT) begin
`ifdef PARITY_EN
                            parity_err <= par_bad;
`endif
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                    S_BREAK: begin
                        if (si == IDLE_LVL) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    ser_deframer_outreg #(.WIDTH(WIDTH)) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .load     (word_done),
        .din      (shreg),
        .po_ready (po_ready),
        .po       (po),
        .po_valid (po_valid),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_ser_deframer.sv
// Self-checking bench for ser_deframer: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_ser_deframer;
    localparam int W = 5;
`ifdef PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         si = 1'b1;
    logic         si_valid = 1'b0;
    logic         msb_first = 1'b1;
    logic         po_ready = 1'b1;
    logic [W-1:0] po;
    logic         po_valid, busy, frame_err, parity_err, ovf;

    ser_deframer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .msb_first(msb_first),
        .po(po), .po_valid(po_valid), .po_ready(po_ready), .busy(busy),
        .frame_err(frame_err), .parity_err(parity_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int spurious = 0;

    // reference model of the output side
    logic         m_valid = 1'b0;
    logic [W-1:0] m_po = '0;
    logic         m_ovf = 1'b0;

    // one clock cycle; caller is always at posedge+1
    task automatic tick(input logic v, input logic b, input logic load,
                        input logic [W-1:0] word, input logic last);
        si_valid = v;
        si = v ? b : 1'($urandom_range(0, 1));
        m_ovf = 1'b0;
        if (load) begin
            if (!m_valid || po_ready) begin
                m_valid = 1'b1;
                m_po    = word;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && po_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        si_valid = 1'b0;
        if (!last && (frame_err || parity_err || ovf)) spurious++;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic msb, input logic stop,
                              input logic par_flip, input int maxgap, input logic rdy_last);
        logic bits[$];
        int   g;
        logic good;
        good = stop && !(HAS_PAR && par_flip);
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(msb ? word[W-1-i] : word[i]);
        if (HAS_PAR) bits.push_back((^word) ^ par_flip);
        bits.push_back(stop);
        msb_first = msb;
        foreach (bits[k]) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int j = 0; j < g; j++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
            if (k == 1) msb_first = 1'($urandom_range(0, 1));
            if (k == bits.size() - 1) begin
                if (rdy_last) po_ready = 1'b1;
                tick(1'b1, bits[k], good, word, 1'b1);
            end else begin
                tick(1'b1, bits[k], 1'b0, '0, 1'b0);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 6;
        if (po !== '0)          begin errors++; $display("FAIL reset_po got %b want 0", po); end
        if (po_valid !== 1'b0)  begin errors++; $display("FAIL reset_po_valid got %b want 0", po_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst = 1'b1;
        m_valid = 1'b0;
        m_po = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_first;
        po_ready = 1'b1;
        send_frame(5'b10110, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        vectors += 3;
        if (po !== 5'b10110)   begin errors++; $display("FAIL msb_po got %b want 10110", po); end
        if (po_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b want 1", po_valid); end
        if (frame_err !== 1'b0 || parity_err !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL msb_errs got %b%b%b want 000", frame_err, parity_err, ovf);
        end
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        vectors++;
        if (po_valid !== 1'b0) begin errors++; $display("FAIL msb_valid_drop got %b want 0", po_valid); end
    endtask

    task automatic test_lsb_first;
        po_ready = 1'b1;
        send_frame(5'b01101, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        vectors += 2;
        if (po !== 5'b01101)   begin errors++; $display("FAIL lsb_po got %b want 01101", po); end
        if (po_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", po_valid); end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_frame_err;
        po_ready = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        send_frame(5'b11001, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        vectors += 3;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b want 1", frame_err); end
        if (po_valid !== 1'b0)  begin errors++; $display("FAIL ferr_valid got %b want 0", po_valid); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL ferr_busy got %b want 1", busy); end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
        vectors += 2;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_one_cycle got %b want 0", frame_err); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL break_hold got %b want 1", busy); end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        vectors++;
        if (busy !== 1'b0)      begin errors++; $display("FAIL break_exit got %b want 0", busy); end
        send_frame(5'b00111, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        vectors += 2;
        if (po !== 5'b00111)    begin errors++; $display("FAIL after_break_po got %b want 00111", po); end
        if (po_valid !== 1'b1)  begin errors++; $display("FAIL after_break_valid got %b want 1", po_valid); end
    endtask

    task automatic test_overflow;
        po_ready = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        po_ready = 1'b0;
        send_frame(5'b10001, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        vectors += 2;
        if (po !== 5'b10001 || po_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_first got %b/%b want 10001/1", po, po_valid);
        end
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_first_pulse got %b want 0", ovf); end
        send_frame(5'b01110, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        vectors += 2;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", ovf); end
        if (po !== 5'b10001 || po_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_held got %b/%b want 10001/1", po, po_valid);
        end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b want 0", ovf); end
        send_frame(5'b11010, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        vectors += 2;
        if (po !== 5'b11010 || po_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_third got %b/%b want 11010/1", po, po_valid);
        end
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_third_pulse got %b want 0", ovf); end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_parity;
        po_ready = 1'b1;
        send_frame(5'b10110, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        vectors += 2;
        if (po_valid !== 1'b1 || po !== 5'b10110) begin
            errors++; $display("FAIL par_good got %b/%b want 10110/1", po, po_valid);
        end
        if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_err got %b want 0", parity_err); end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef PARITY_EN
        send_frame(5'b10110, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        vectors += 2;
        if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b want 1", parity_err); end
        if (po_valid !== 1'b0)   begin errors++; $display("FAIL par_bad_valid got %b want 0", po_valid); end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL par_one_cycle got %b want 0", parity_err); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        po_ready = 1'b1;
        msb_first = 1'b1;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        vectors += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (po_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", po_valid); end
        m_valid = 1'b0;
        m_po = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(5'b01011, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        vectors++;
        if (po !== 5'b01011 || po_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_frame got %b/%b want 01011/1", po, po_valid);
        end
    endtask

    task automatic test_gaps;
        logic [W-1:0] first;
        logic [W-1:0] w;
        po_ready = 1'b1;
        w = W'($urandom);
        send_frame(w, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        first = po;
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        send_frame(w, 1'b0, 1'b1, 1'b0, 5, 1'b1);
        vectors += 2;
        if (po !== first) begin errors++; $display("FAIL gaps_same got %b want %b", po, first); end
        if (po !== w || po_valid !== 1'b1) begin
            errors++; $display("FAIL gaps_word got %b/%b want %b/1", po, po_valid, w);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] w;
        logic msb, stop, pflip, rdy;
        for (int n = 0; n < 40; n++) begin
            w     = W'($urandom);
            msb   = 1'($urandom_range(0, 1));
            stop  = ($urandom_range(0, 7) != 0);
            pflip = HAS_PAR && ($urandom_range(0, 5) == 0);
            rdy   = 1'($urandom_range(0, 1));
            po_ready = 1'($urandom_range(0, 1));
            send_frame(w, msb, stop, pflip, (n % 2 == 0) ? 0 : 3, rdy);
            vectors += 5;
            if (po_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_valid got %b want %b", n, po_valid, m_valid); end
            if (po !== m_po)          begin errors++; $display("FAIL rnd%0d_po got %b want %b", n, po, m_po); end
            if (ovf !== m_ovf)        begin errors++; $display("FAIL rnd%0d_ovf got %b want %b", n, ovf, m_ovf); end
            if (frame_err !== !stop)  begin errors++; $display("FAIL rnd%0d_ferr got %b want %b", n, frame_err, !stop); end
            if (parity_err !== (stop && pflip)) begin
                errors++; $display("FAIL rnd%0d_perr got %b want %b", n, parity_err, stop && pflip);
            end
            if (!stop) begin
                tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
                tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
                vectors++;
                if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_break got %b want 0", n, busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_frame_err();
        test_overflow();
        test_parity();
        test_reset_mid_frame();
        test_gaps();
        test_random();
        vectors++;
        if (spurious !== 0) begin errors++; $display("FAIL spurious_pulses got %0d want 0", spurious); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ser_deframer.md
# ser_deframer

Serial frame receiver that sits directly downstream of the universal shift register's serial output. It samples qualified serial bits, detects start/stop framing, assembles WIDTH-bit words MSB-first or LSB-first, and presents each word on a valid/ready parallel port. Framing, parity and overflow errors are reported as single-cycle pulses.

## Interface
- WIDTH, 5, data bits per frame (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; asserted when 0
- si  input  1  serial data bit (idle level 1)
- si_valid  input  1  qualifies si for exactly one cycle; bits with si_valid=0 are ignored
- msb_first  input  1  1: first data bit → po[WIDTH-1] (shift-left assembly); 0: first data bit → po[0] (shift-right assembly); sampled on the start bit
- po  output  WIDTH  received word; held stable while po_valid=1
- po_valid  output  1  word available
- po_ready  input  1  consumer accepts word when po_valid && po_ready
- busy  output  1  1 in any state other than IDLE
- frame_err  output  1  one-cycle pulse: stop bit was 0
- parity_err  output  1  one-cycle pulse: parity mismatch (0 when PARITY_EN undefined)
- ovf  output  1  one-cycle pulse: completed word dropped because output register full

## Operation
- Frame on accepted bits: start (0), WIDTH data bits, [parity bit], stop (1).
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: accepted bit 0 → DATA, bit_cnt=0, latch msb_first, clear shift reg; accepted bit 1 → stay.
- DATA: each accepted bit shifts into internal shift reg per latched direction; bit_cnt increments; on bit WIDTH-1 → PARITY if PARITY_EN, else STOP.
- PARITY: accepted bit compared to even parity of data bits (XOR of data XOR parity bit must be 0); result held → STOP.
- STOP: accepted bit 1 → word complete → IDLE; accepted bit 0 → frame_err, word discarded, → BREAK.
- BREAK: stays until an accepted bit 1, → IDLE (a 0 never starts a frame from BREAK).
- Word complete with parity mismatch: parity_err pulses, word discarded.
- Word complete, good: if output register empty, or po_ready=1 in the same cycle, load po and set po_valid; otherwise ovf pulses, new word dropped, held word unchanged.
- Handshake: po_valid clears on po_valid && po_ready unless a new word loads in that same cycle (then stays 1, po updates).
- Errors never alter po/po_valid.

## Timing
- Reset values: po=0, po_valid=0, busy=0, frame_err=0, parity_err=0, ovf=0; FSM=IDLE, bit_cnt=0.
- Reset mid-frame: partial word lost, FSM to IDLE immediately (asynchronous).
- Latency: po_valid rises the clk edge that accepts the stop bit (visible next cycle).
- frame_err/parity_err/ovf assert on that same edge for one cycle only.
- Back-to-back frames with si_valid every cycle fully supported; zero idle bits between stop and next start allowed.
- bit_cnt width $clog2(WIDTH); no wrap beyond WIDTH-1.

## Configuration
- PARITY_EN defined: frames carry one even-parity bit after data; PARITY state present; parity_err functional.
- PARITY_EN undefined: no parity bit; DATA → STOP directly; parity_err tied 0.

## Structure
- Shared package: FSM state enum (IDLE, DATA, PARITY, STOP, BREAK) and idle-level/start/stop bit constants.
- One sub-module natural: ser_deframer_outreg — the output holding register with valid/ready and overflow detection.

## Test plan
- WIDTH=5, no parity, msb_first=1, bits 0,1,0,1,1,0,1 with si_valid every cycle, po_ready=1 → po=5'b10110, po_valid one cycle, no errors.
- Same bits, msb_first=0 → po=5'b01101.
- Stop bit 0 followed by 0,0,1,0... → frame_err pulse, no po_valid, zeros ignored until a 1, then next frame received normally.
- po_ready=0, two good frames → first word held, ovf pulse on second stop bit; po_ready=1 on the stop-bit cycle of a third frame → third word loads, no ovf.
- PARITY_EN, data 5'b10110 with parity 1 → po_valid; parity 0 → parity_err pulse, no po_valid.
- rst low for one cycle mid-DATA → busy=0, next start bit begins a clean frame; si_valid gaps of random length inside a frame → identical po.
